integer_writeback: RTL and testbench

Result-retirement stage paired with the CPU integer ALU in the sha256crypt controller. It captures the ALU's registered result words and the `dout_select` tag one cycle after issue, muxes the selected word and queues the register-file write, with backpressure to the issue stage. It also owns the architectural CF/OF/ZF flag register, sampling the ALU's combinational flags in the issue cycle and feeding CF back as the ALU carry input.

---
 rtl/integer_writeback_pkg.sv | 16 +
 rtl/wb_fifo2.sv | 74 +++++++
 rtl/integer_writeback.sv | 131 +++++++++++++
 tb/tb_integer_writeback.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/integer_writeback_pkg.sv
// Shared encodings for the integer ALU result path: dout_select tags and
// flag-update mask bit positions, common to the ALU decoder and writeback.
package integer_writeback_pkg;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_ADDSUB = 2'd1,
    SEL_GRP2   = 2'd2,
    SEL_GRP3   = 2'd3
  } dout_sel_e;

  localparam int unsigned FLG_CF = 2;
  localparam int unsigned FLG_OF = 1;
  localparam int unsigned FLG_ZF = 0;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order write queue; entry 0 is always the head, entry 1 the
// younger entry when two are held. Both entries are visible for forwarding.
module wb_fifo2 #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [WIDTH-1:0]      head_data,
  output logic                  tail_valid,
  output logic [ADDR_WIDTH-1:0] tail_addr,
  output logic [WIDTH-1:0]      tail_data
);

  logic [1:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] e0_addr_q, e0_addr_d, e1_addr_q, e1_addr_d;
  logic [WIDTH-1:0]      e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic                  pop_ok;
  logic                  slot_hi;

  always_comb begin
    pop_ok    = pop && (count_q != 2'd0);
    // Slot is chosen after the pop shifts entry 1 down, so push+pop keeps order.
    slot_hi   = (count_q - 2'(pop_ok)) != 2'd0;
    count_d   = count_q + 2'(push) - 2'(pop_ok);
    e0_addr_d = e0_addr_q;
    e0_data_d = e0_data_q;
    e1_addr_d = e1_addr_q;
    e1_data_d = e1_data_q;
    if (pop_ok) begin
      e0_addr_d = e1_addr_q;
      e0_data_d = e1_data_q;
    end
    if (push) begin
      if (slot_hi) begin
        e1_addr_d = push_addr;
        e1_data_d = push_data;
      end else begin
        e0_addr_d = push_addr;
        e0_data_d = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      e0_addr_q <= '0;
      e0_data_q <= '0;
      e1_addr_q <= '0;
      e1_data_q <= '0;
    end else begin
      count_q   <= count_d;
      e0_addr_q <= e0_addr_d;
      e0_data_q <= e0_data_d;
      e1_addr_q <= e1_addr_d;
      e1_data_q <= e1_data_d;
    end
  end

  assign count      = count_q;
  assign head_addr  = e0_addr_q;
  assign head_data  = e0_data_q;
  assign tail_valid = (count_q == 2'd2);
  assign tail_addr  = e1_addr_q;
  assign tail_data  = e1_data_q;

endmodule

// File: rtl/integer_writeback.sv
// Integer ALU result retirement: S1 capture, result mux, 2-deep write queue,
// CF/OF/ZF register. Optional operand forwarding under `WB_BYPASS_EN.
module integer_writeback
  import integer_writeback_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iop_valid,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [2:0]            flags_upd,
  input  logic                  flag_cf,
  input  logic                  flag_of,
  input  logic                  flag_zf,
  input  logic [1:0]            dout_select,
  input  logic [WIDTH-1:0]      dout1,
  input  logic [WIDTH-1:0]      dout2,
  input  logic [WIDTH-1:0]      dout3,
  output logic                  busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_ready,
  output logic                  cf,
  output logic                  of,
  output logic                  zf,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  byp_hit,
  output logic [WIDTH-1:0]      byp_data
);

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [2:0]            flags_q, flags_d;
  logic                  issue_ok;
  logic                  retire_push;
  logic [WIDTH-1:0]      result;
  logic [1:0]            fifo_count;
  logic                  tail_valid;
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic [WIDTH-1:0]      tail_data;

  // Registers only, so wr_ready never reaches busy combinationally.
  assign busy     = ({1'b0, fifo_count} + {2'b00, s1_valid_q}) >= 3'd2;
  assign issue_ok = iop_valid & ~busy;

  always_comb begin
    result = '0;
    case (dout_select)
      SEL_ADDSUB: result = dout1;
      SEL_GRP2:   result = dout2;
      SEL_GRP3:   result = dout3;
      default:    result = '0;
    endcase
    retire_push = s1_valid_q & (dout_select != SEL_NONE);
  end

  always_comb begin
    s1_valid_d = issue_ok;
    s1_addr_d  = issue_ok ? dst_addr : s1_addr_q;
    flags_d    = flags_q;
    if (issue_ok) begin
      if (flags_upd[FLG_CF]) flags_d[FLG_CF] = flag_cf;
      if (flags_upd[FLG_OF]) flags_d[FLG_OF] = flag_of;
      if (flags_upd[FLG_ZF]) flags_d[FLG_ZF] = flag_zf;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      flags_q    <= flags_d;
    end
  end

  assign cf    = flags_q[FLG_CF];
  assign of    = flags_q[FLG_OF];
  assign zf    = flags_q[FLG_ZF];
  assign wr_en = (fifo_count != 2'd0);

  wb_fifo2 #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (retire_push),
    .push_addr  (s1_addr_q),
    .push_data  (result),
    .pop        (wr_en & wr_ready),
    .count      (fifo_count),
    .head_addr  (wr_addr),
    .head_data  (wr_data),
    .tail_valid (tail_valid),
    .tail_addr  (tail_addr),
    .tail_data  (tail_data)
  );

`ifdef WB_BYPASS_EN
  // Later assignments win: S1 overrides FIFO tail, which overrides head.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (wr_en && (wr_addr == rd_addr)) begin
      byp_hit  = 1'b1;
      byp_data = wr_data;
    end
    if (tail_valid && (tail_addr == rd_addr)) begin
      byp_hit  = 1'b1;
      byp_data = tail_data;
    end
    if (retire_push && (s1_addr_q == rd_addr)) begin
      byp_hit  = 1'b1;
      byp_data = result;
    end
  end
`else
  logic byp_unused;
  assign byp_unused = ^{rd_addr, tail_valid, tail_addr, tail_data};
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_integer_writeback.sv
// Scoreboard bench for integer_writeback: directed scenarios then random traffic
// against a queue-based reference model.
module tb_integer_writeback;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          iop_valid = 1'b0;
  logic [AW-1:0] dst_addr = '0;
  logic [2:0]    flags_upd = '0;
  logic          flag_cf = 1'b0, flag_of = 1'b0, flag_zf = 1'b0;
  logic [1:0]    dout_select = '0;
  logic [W-1:0]  dout1 = '0, dout2 = '0, dout3 = '0;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_ready = 1'b1;
  logic          cf, of, zf;
  logic [AW-1:0] rd_addr = '0;
  logic          byp_hit;
  logic [W-1:0]  byp_data;

  always #5 CLK = ~CLK;

  integer_writeback #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .iop_valid(iop_valid), .dst_addr(dst_addr),
    .flags_upd(flags_upd), .flag_cf(flag_cf), .flag_of(flag_of), .flag_zf(flag_zf),
    .dout_select(dout_select), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .cf(cf), .of(of), .zf(zf),
    .rd_addr(rd_addr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  wr_t           exp_q[$];
  bit            m_s1 = 1'b0;
  logic [AW-1:0] m_s1_addr = '0;
  bit            m_cf = 1'b0, m_of = 1'b0, m_zf = 1'b0;
  bit            m_busy = 1'b0;
  int            errors = 0;
  int            checks = 0;
  int            writes_seen = 0;

  function automatic logic [W-1:0] pick_word();
    case (dout_select)
      2'd1:    return dout1;
      2'd2:    return dout2;
      2'd3:    return dout3;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: outstanding writes are a queue in program order; an issue is
  // accepted only when fewer than two results are in flight.
  initial forever begin
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      m_s1 = 1'b0;
      m_cf = 1'b0; m_of = 1'b0; m_zf = 1'b0;
    end else begin
      bit accept;
      accept = iop_valid && !m_busy;
      if (exp_q.size() > 0 && wr_ready) void'(exp_q.pop_front());
      if (m_s1 && dout_select != 2'd0) exp_q.push_back('{a: m_s1_addr, d: pick_word()});
      if (accept) begin
        if (flags_upd[2]) m_cf = flag_cf;
        if (flags_upd[1]) m_of = flag_of;
        if (flags_upd[0]) m_zf = flag_zf;
      end
      m_s1      = accept;
      m_s1_addr = dst_addr;
    end
    m_busy = (exp_q.size() + int'(m_s1)) >= 2;
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial forever begin
    bit            eh;
    logic [W-1:0]  ed;
    @(negedge CLK);
    chk("wr_en", wr_en, exp_q.size() > 0);
    if (wr_en && exp_q.size() > 0) begin
      chk("wr_addr", wr_addr, exp_q[0].a);
      chk("wr_data", wr_data, exp_q[0].d);
      if (wr_ready) writes_seen++;
    end
    chk("busy", busy, m_busy);
    chk("flags", {cf, of, zf}, {m_cf, m_of, m_zf});
    eh = 1'b0;
    ed = '0;
`ifdef WB_BYPASS_EN
    foreach (exp_q[i]) begin
      if (exp_q[i].a == rd_addr) begin
        eh = 1'b1;
        ed = exp_q[i].d;
      end
    end
    if (m_s1 && dout_select != 2'd0 && m_s1_addr == rd_addr) begin
      eh = 1'b1;
      ed = pick_word();
    end
`endif
    chk("byp_hit", byp_hit, eh);
    if (eh) chk("byp_data", byp_data, ed);
    else    chk("byp_data_idle", byp_data, '0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    iop_valid   = 1'b0;
    flags_upd   = '0;
    flag_cf     = 1'b0; flag_of = 1'b0; flag_zf = 1'b0;
    dout_select = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [2:0] upd);
    iop_valid = 1'b1;
    dst_addr  = a;
    flags_upd = upd;
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    wr_ready = 1'b1;

    // single write, latency 2
    issue(4'd3, 3'b000); step();
    idle(); dout_select = 2'd1; dout1 = 16'h1234; step();
    idle(); step(); step();

    // masked flag update
    issue(4'd1, 3'b101); flag_cf = 1'b1; flag_of = 1'b1; flag_zf = 1'b1; step();
    idle(); step(); step();

    // tag 0 drops the result but flags still update
    issue(4'd2, 3'b010); flag_of = 1'b1; step();
    idle(); dout_select = 2'd0; dout2 = 16'hBEEF; step();
    idle(); step(); step();

    // backpressure: third back-to-back issue blocked
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(AW'(8 + i), 3'b000);
      dout_select = (i == 0) ? 2'd0 : 2'd2;
      dout2 = 16'h0A00 + 16'(i);
      step();
    end
    idle(); dout_select = 2'd2; dout2 = 16'h0A02; step();
    idle(); repeat (3) step();
    wr_ready = 1'b1;
    repeat (4) step();

    // two pending writes to reg 5, youngest forwarded
    wr_ready = 1'b0;
    rd_addr  = 4'd5;
    issue(4'd5, 3'b000); step();
    issue(4'd5, 3'b000); dout_select = 2'd1; dout1 = 16'h0011; step();
    idle(); dout_select = 2'd1; dout1 = 16'h0022; step();
    idle(); repeat (2) step();

    // reset with FIFO full
    RST = 1'b1; step();
    RST = 1'b0; wr_ready = 1'b1;
    repeat (3) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom_range(0, 249) == 0);
      iop_valid   = ($urandom_range(0, 9) < 6);
      dst_addr    = AW'($urandom_range(0, 3));
      flags_upd   = 3'($urandom);
      flag_cf     = 1'($urandom);
      flag_of     = 1'($urandom);
      flag_zf     = 1'($urandom);
      dout_select = 2'($urandom);
      dout1       = W'($urandom);
      dout2       = W'($urandom);
      dout3       = W'($urandom);
      wr_ready    = ($urandom_range(0, 9) < 7);
      rd_addr     = AW'($urandom_range(0, 4));
      step();
    end
    RST = 1'b0;
    idle();
    wr_ready = 1'b1;
    repeat (5) step();

    chk("writes_retired_nonzero", writes_seen > 10, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
